rv_decode_stage: RTL and testbench
==================================

// Module: rv_decode_stage
// PURPOSE
//  Registered RV32I/RV64I decode stage with valid/ready handshakes on both sides and a 2-entry skid buffer.
//  Sits between fetch and execute. Consumes {pc, inst} and produces a decoded control bundle one cycle later.
//  Adds what the previous decoder lacked: back-pressure, flush, illegal-instruction detection and XLEN generality.
// PARAMETERS
//  XLEN      32  datapath width, 32 or 64; sets imm_o/pc width; RV64 W-ops (0011011/0111011) flagged illegal
//  ALU_OP_W   4  alu_op_o width; >=4 required
// PORTS
//  clk_i            in   1     clock, single domain
//  rst_i            in   1     synchronous, active-high reset
//  flush_i          in   1     discard all held and incoming instructions
//  inst_valid_i     in   1     fetch bundle valid
//  inst_ready_o     out  1     stage can accept; registered, = !skid_full
//  inst_i           in   32    instruction word
//  pc_i             in   XLEN  instruction address
//  dec_valid_o      out  1     decoded bundle valid
//  dec_ready_i      in   1     execute accepts bundle
//  pc_o             out  XLEN  pc of decoded instruction
//  alu_op_o         out  ALU_OP_W  0 add,1 sub,2 and,3 or,4 xor,5 sll,6 srl,7 sra,8-15 M ops (mul..remu in funct3 order)
//  imm_o            out  XLEN  sign-extended immediate (I/S/B/U/J); 0 for R-type
//  rs1_o/rs2_o/rd_o out  5     register indices
//  src_a_sel_o      out  2     0 rs1, 1 pc, 3 zero
//  src_b_sel_o      out  2     0 rs2, 1 imm
//  reg_src_sel_o    out  2     0 alu, 1 mem, 2 cmp, 3 pc+4
//  pc_src_sel_o     out  2     0 seq, 1 branch, 2 jal/jalr
//  cmp_sel_o        out  2     0 eq, 1 ne, 2 lt, 3 ge
//  cmp_signed_o     out  1     1 = signed compare (blt/bge/slt/slti)
//  mem_size_o       out  3     funct3 of load/store; 0 otherwise
//  wr_mem_o         out  1     store
//  wr_reg_o         out  1     register writeback; forced 0 when rd==0
//  illegal_o        out  1     undecodable instruction
// BEHAVIOUR
//  Reset: while rst_i=1, dec_valid_o=0, inst_ready_o=0, skid empty, all bundle outputs 0; inst_ready_o=1 the cycle after release.
//  Transfer on a side occurs when valid&ready are both high at a rising edge. Latency: accept at edge N -> dec_valid_o=1 after edge N.
//  Storage: main (output) register + skid register. Input accepted while main is full and dec_ready_i=0 goes to skid.
//   Skid drains to main on the next output transfer. Throughput is 1/cycle with no bubble when dec_ready_i=1.
//  inst_ready_o deasserts the cycle after skid fills and reasserts the cycle after skid drains; never combinational from dec_ready_i.
//  dec_valid_o and the bundle stay stable while dec_valid_o=1 and dec_ready_i=0.
//  flush_i at edge N: main and skid empty after N; any input transfer at N is dropped; flush beats simultaneous accept and drain.
//  Illegal: unknown opcode; load funct3 in {3,6,7}; store funct3>2; branch funct3 in {2,3}; OP funct7 not 0x00/0x20 (0x01 per macro);
//   funct7=0x20 on other than add/sra; slli/srli funct7!=0, srai funct7!=0x20 (RV64: funct7[6:1]).
//   An illegal instruction is still presented with illegal_o=1, wr_reg_o=wr_mem_o=0 and pc_src_sel_o=0.
//  Decode table matches existing RV32I control encodings. lui: src_a=3,src_b=1; auipc: src_a=1; branch/jal: src_a=1, alu add.
//  slt/sltu/slti/sltiu: reg_src=2, cmp_sel=2, cmp_signed=1 for slt/slti only. jal/jalr: reg_src=3, pc_src=2.
//  Immediates are sign-extended from inst[31] to XLEN. U-type is {inst[31:12],12'b0} sign-extended.
// CONFIGURATION
//  RV_DECODE_M_EXT_EN defined: OP with funct7=0x01 decodes to alu_op 8+funct3 (mul,mulh,mulhsu,mulhu,div,divu,rem,remu), reg_src=0.
//  Undefined: funct7=0x01 is illegal; alu_op never exceeds 7.
// STRUCTURE
//  Package rv_decode_pkg holds: opcode localparams; alu_op_e; src_a/src_b/reg_src/pc_src/cmp sel enums;
//   decode_bundle_t struct (all bundle fields), used for main/skid registers.
//  Sub-module rv_imm_gen: combinational, (inst, XLEN) -> imm, instantiated once on the incoming word.
//  The decode function is combinational on inst_i; only the bundle is registered.
// TESTING
//  addi x5,x1,-1 (0xFFF08293), pc=0x100 -> 1 cycle later: alu_op=0, imm=0xFFFFFFFF, rd=5, wr_reg=1, src_b=1, pc_o=0x100.
//  Stream 4 instrs with dec_ready_i=0 -> 2 held (main+skid), inst_ready_o=0 one cycle after skid fills.
//   Then release -> 4 outputs in order, no drops.
//  beq x0,x0,-4 (0xFE000EE3) -> imm=0xFFFFFFFC, pc_src=1, cmp_sel=0, wr_reg=0, illegal=0.
//  0x00000000 and funct3=3 load -> illegal_o=1, wr_reg=0, wr_mem=0, dec_valid_o=1.
//  mul x3,x1,x2 (0x022081B3) -> with macro: alu_op=8, illegal=0; without: illegal_o=1.
//  flush_i with main+skid full and inst_valid_i=1 -> next cycle dec_valid_o=0, inst_ready_o=1, flushed word never appears.
//   Also: rst_i mid-stream -> all outputs 0.

Source files
------------

// File: rtl/rv_decode_pkg.sv
// Shared types for the RV32I/RV64I decode stage: opcode constants, select
// enums, the registered decode bundle and the base ALU op helper.
// Bundle pc/imm are held at 64 bits; narrower XLEN builds use the low bits.
package rv_decode_pkg;

  localparam int XLEN_MAX = 64;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2, ALU_OR = 4'd3,
    ALU_XOR = 4'd4, ALU_SLL = 4'd5, ALU_SRL = 4'd6, ALU_SRA = 4'd7,
    ALU_MUL = 4'd8, ALU_MULH = 4'd9, ALU_MULHSU = 4'd10, ALU_MULHU = 4'd11,
    ALU_DIV = 4'd12, ALU_DIVU = 4'd13, ALU_REM = 4'd14, ALU_REMU = 4'd15
  } alu_op_e;

  typedef enum logic [1:0] {SRC_A_RS1 = 2'd0, SRC_A_PC = 2'd1, SRC_A_ZERO = 2'd3} src_a_e;
  typedef enum logic [1:0] {SRC_B_RS2 = 2'd0, SRC_B_IMM = 2'd1} src_b_e;
  typedef enum logic [1:0] {REG_SRC_ALU = 2'd0, REG_SRC_MEM = 2'd1, REG_SRC_CMP = 2'd2, REG_SRC_PC4 = 2'd3} reg_src_e;
  typedef enum logic [1:0] {PC_SRC_SEQ = 2'd0, PC_SRC_BRANCH = 2'd1, PC_SRC_JUMP = 2'd2} pc_src_e;
  typedef enum logic [1:0] {CMP_EQ = 2'd0, CMP_NE = 2'd1, CMP_LT = 2'd2, CMP_GE = 2'd3} cmp_e;

  typedef struct packed {
    logic [XLEN_MAX-1:0] pc;
    alu_op_e             alu_op;
    logic [XLEN_MAX-1:0] imm;
    logic [4:0]          rs1;
    logic [4:0]          rs2;
    logic [4:0]          rd;
    src_a_e              src_a;
    src_b_e              src_b;
    reg_src_e            reg_src;
    pc_src_e             pc_src;
    cmp_e                cmp_sel;
    logic                cmp_signed;
    logic [2:0]          mem_size;
    logic                wr_mem;
    logic                wr_reg;
    logic                illegal;
  } decode_bundle_t;

  // Integer ALU op for OP/OP-IMM; alt selects sub/sra (inst[30]).
  // slt/sltu map to add: the result comes from the comparator instead.
  function automatic alu_op_e base_alu_op(input logic [2:0] f3, input logic alt);
    case (f3)
      3'd0:    return alt ? ALU_SUB : ALU_ADD;
      3'd1:    return ALU_SLL;
      3'd4:    return ALU_XOR;
      3'd5:    return alt ? ALU_SRA : ALU_SRL;
      3'd6:    return ALU_OR;
      3'd7:    return ALU_AND;
      default: return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/rv_decode_if.sv
// Fetch-side and execute-side handshake bundle of the decode stage.
// slave: the decode stage view; master: the fetch/execute (or bench) view.
// Ports: inst_valid/ready, inst, pc in; dec_valid/ready and decoded fields out.
interface rv_decode_if #(
  parameter int XLEN     = 32,
  parameter int ALU_OP_W = 4
);
  logic                inst_valid_i;
  logic                inst_ready_o;
  logic [31:0]         inst_i;
  logic [XLEN-1:0]     pc_i;
  logic                dec_valid_o;
  logic                dec_ready_i;
  logic [XLEN-1:0]     pc_o;
  logic [ALU_OP_W-1:0] alu_op_o;
  logic [XLEN-1:0]     imm_o;
  logic [4:0]          rs1_o;
  logic [4:0]          rs2_o;
  logic [4:0]          rd_o;
  logic [1:0]          src_a_sel_o;
  logic [1:0]          src_b_sel_o;
  logic [1:0]          reg_src_sel_o;
  logic [1:0]          pc_src_sel_o;
  logic [1:0]          cmp_sel_o;
  logic                cmp_signed_o;
  logic [2:0]          mem_size_o;
  logic                wr_mem_o;
  logic                wr_reg_o;
  logic                illegal_o;

  modport slave (
    input  inst_valid_i, inst_i, pc_i, dec_ready_i,
    output inst_ready_o, dec_valid_o, pc_o, alu_op_o, imm_o, rs1_o, rs2_o, rd_o,
           src_a_sel_o, src_b_sel_o, reg_src_sel_o, pc_src_sel_o, cmp_sel_o,
           cmp_signed_o, mem_size_o, wr_mem_o, wr_reg_o, illegal_o
  );

  modport master (
    output inst_valid_i, inst_i, pc_i, dec_ready_i,
    input  inst_ready_o, dec_valid_o, pc_o, alu_op_o, imm_o, rs1_o, rs2_o, rd_o,
           src_a_sel_o, src_b_sel_o, reg_src_sel_o, pc_src_sel_o, cmp_sel_o,
           cmp_signed_o, mem_size_o, wr_mem_o, wr_reg_o, illegal_o
  );
endinterface

// File: rtl/rv_imm_gen.sv
// Immediate generator: I/S/B/U/J immediates sign-extended from inst[31] to XLEN.
// Ports: inst_i (32) in, imm_o (XLEN) out; purely combinational.
// R-type and unknown opcodes yield 0.
module rv_imm_gen
  import rv_decode_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     inst_i,
  output logic [XLEN-1:0] imm_o
);
  logic [31:0] imm32;

  always_comb begin
    imm32 = '0;
    case (inst_i[6:0])
      OPC_LOAD, OPC_OP_IMM, OPC_JALR:
        imm32 = {{20{inst_i[31]}}, inst_i[31:20]};
      OPC_STORE:
        imm32 = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
      OPC_BRANCH:
        imm32 = {{19{inst_i[31]}}, inst_i[31], inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};
      OPC_LUI, OPC_AUIPC:
        imm32 = {inst_i[31:12], 12'b0};
      OPC_JAL:
        imm32 = {{11{inst_i[31]}}, inst_i[31], inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0};
      default:
        imm32 = '0;
    endcase
  end

  // Every 32-bit form already carries inst[31] in bit 31, so one more sign
  // extension reaches XLEN.
  assign imm_o = XLEN'($signed(imm32));
endmodule

// File: rtl/rv_decode_stage.sv
// Registered RV32I/RV64I decode stage: {pc, inst} in, decoded bundle out one cycle later.
// Ports: clk_i, rst_i (sync, active-high), flush_i, bus (rv_decode_if.slave).
// Main + skid registers; inst_ready_o registered as !skid_full. Macro RV_DECODE_M_EXT_EN enables M ops.
module rv_decode_stage
  import rv_decode_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int ALU_OP_W = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         flush_i,
  rv_decode_if.slave   bus
);
  logic [XLEN-1:0] imm_w;
  logic [31:0]     inst;
  logic [6:0]      opc;
  logic [2:0]      f3;
  logic [6:0]      f7;
  logic [6:0]      f7_sh;
  decode_bundle_t  dec;

  decode_bundle_t  main_q, main_d, skid_q, skid_d;
  logic            main_vld_q, main_vld_d, skid_vld_q, skid_vld_d, rdy_q;
  logic            in_fire, out_fire;

  rv_imm_gen #(.XLEN(XLEN)) u_imm_gen (.inst_i(bus.inst_i), .imm_o(imm_w));

  assign inst = bus.inst_i;
  assign opc  = inst[6:0];
  assign f3   = inst[14:12];
  assign f7   = inst[31:25];
  // RV64 shift amounts are 6 bits wide, so only funct7[6:1] qualifies the op.
  assign f7_sh = (XLEN == 64) ? {inst[31:26], 1'b0} : inst[31:25];

  always_comb begin
    dec     = '0;
    dec.pc  = 64'(bus.pc_i);
    dec.imm = 64'($signed(imm_w));
    dec.rs1 = inst[19:15];
    dec.rs2 = inst[24:20];
    dec.rd  = inst[11:7];
    case (opc)
      OPC_LUI: begin
        dec.src_a = SRC_A_ZERO; dec.src_b = SRC_B_IMM; dec.wr_reg = 1'b1;
      end
      OPC_AUIPC: begin
        dec.src_a = SRC_A_PC; dec.src_b = SRC_B_IMM; dec.wr_reg = 1'b1;
      end
      OPC_JAL: begin
        dec.src_a = SRC_A_PC; dec.src_b = SRC_B_IMM;
        dec.reg_src = REG_SRC_PC4; dec.pc_src = PC_SRC_JUMP; dec.wr_reg = 1'b1;
      end
      OPC_JALR: begin
        dec.src_b = SRC_B_IMM;
        dec.reg_src = REG_SRC_PC4; dec.pc_src = PC_SRC_JUMP; dec.wr_reg = 1'b1;
      end
      OPC_BRANCH: begin
        // funct3 {0,1,4,5,6,7} -> eq,ne,lt,ge,ltu,geu; bit1 marks unsigned.
        dec.src_a = SRC_A_PC; dec.src_b = SRC_B_IMM; dec.pc_src = PC_SRC_BRANCH;
        dec.cmp_sel    = cmp_e'({f3[2], f3[0]});
        dec.cmp_signed = f3[2] & ~f3[1];
        dec.illegal    = (f3[2:1] == 2'b01);
      end
      OPC_LOAD: begin
        dec.src_b = SRC_B_IMM; dec.reg_src = REG_SRC_MEM;
        dec.mem_size = f3; dec.wr_reg = 1'b1;
        dec.illegal = (f3 == 3'd3) || (f3 >= 3'd6);
      end
      OPC_STORE: begin
        dec.src_b = SRC_B_IMM; dec.mem_size = f3; dec.wr_mem = 1'b1;
        dec.illegal = (f3 > 3'd2);
      end
      OPC_OP_IMM: begin
        dec.src_b  = SRC_B_IMM;
        dec.wr_reg = 1'b1;
        dec.alu_op = base_alu_op(f3, (f3 == 3'd5) && inst[30]);
        if (f3 == 3'd2 || f3 == 3'd3) begin
          dec.reg_src = REG_SRC_CMP; dec.cmp_sel = CMP_LT; dec.cmp_signed = (f3 == 3'd2);
        end
        if (f3 == 3'd1) dec.illegal = (f7_sh != 7'h00);
        if (f3 == 3'd5) dec.illegal = (f7_sh != 7'h00) && (f7_sh != 7'h20);
      end
      OPC_OP: begin
        dec.wr_reg = 1'b1;
        case (f7)
          7'h00: begin
            dec.alu_op = base_alu_op(f3, 1'b0);
            if (f3 == 3'd2 || f3 == 3'd3) begin
              dec.reg_src = REG_SRC_CMP; dec.cmp_sel = CMP_LT; dec.cmp_signed = (f3 == 3'd2);
            end
          end
          7'h20: begin
            dec.alu_op  = base_alu_op(f3, 1'b1);
            dec.illegal = (f3 != 3'd0) && (f3 != 3'd5);
          end
`ifdef RV_DECODE_M_EXT_EN
          7'h01: dec.alu_op = alu_op_e'({1'b1, f3});
`else
          7'h01: dec.illegal = 1'b1;
`endif
          default: dec.illegal = 1'b1;
        endcase
      end
      default: dec.illegal = 1'b1;
    endcase
    // Illegal words still flow down the pipe but must not change state.
    if (dec.illegal) begin
      dec.wr_reg = 1'b0;
      dec.wr_mem = 1'b0;
      dec.pc_src = PC_SRC_SEQ;
    end
    if (dec.rd == 5'd0) dec.wr_reg = 1'b0;
  end

  assign in_fire  = bus.inst_valid_i & rdy_q;
  assign out_fire = main_vld_q & bus.dec_ready_i;

  always_comb begin
    main_d     = main_q;
    skid_d     = skid_q;
    main_vld_d = main_vld_q;
    skid_vld_d = skid_vld_q;
    if (flush_i) begin
      main_vld_d = 1'b0;
      skid_vld_d = 1'b0;
    end else if (!main_vld_q || out_fire) begin
      // Main slot frees up: the older skid entry moves first, new word behind it.
      if (skid_vld_q) begin
        main_d     = skid_q;
        main_vld_d = 1'b1;
        skid_vld_d = in_fire;
        if (in_fire) skid_d = dec;
      end else begin
        main_vld_d = in_fire;
        if (in_fire) main_d = dec;
      end
    end else if (in_fire) begin
      skid_d     = dec;
      skid_vld_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      main_q     <= '0;
      skid_q     <= '0;
      main_vld_q <= 1'b0;
      skid_vld_q <= 1'b0;
      rdy_q      <= 1'b0;
    end else begin
      main_q     <= main_d;
      skid_q     <= skid_d;
      main_vld_q <= main_vld_d;
      skid_vld_q <= skid_vld_d;
      rdy_q      <= !skid_vld_d;
    end
  end

  assign bus.inst_ready_o  = rdy_q;
  assign bus.dec_valid_o   = main_vld_q;
  assign bus.pc_o          = XLEN'(main_q.pc);
  assign bus.imm_o         = XLEN'(main_q.imm);
  assign bus.alu_op_o      = ALU_OP_W'(main_q.alu_op);
  assign bus.rs1_o         = main_q.rs1;
  assign bus.rs2_o         = main_q.rs2;
  assign bus.rd_o          = main_q.rd;
  assign bus.src_a_sel_o   = main_q.src_a;
  assign bus.src_b_sel_o   = main_q.src_b;
  assign bus.reg_src_sel_o = main_q.reg_src;
  assign bus.pc_src_sel_o  = main_q.pc_src;
  assign bus.cmp_sel_o     = main_q.cmp_sel;
  assign bus.cmp_signed_o  = main_q.cmp_signed;
  assign bus.mem_size_o    = main_q.mem_size;
  assign bus.wr_mem_o      = main_q.wr_mem;
  assign bus.wr_reg_o      = main_q.wr_reg;
  assign bus.illegal_o     = main_q.illegal;
endmodule

// File: tb/tb_rv_decode_stage.sv
// Directed bench for rv_decode_stage (XLEN=32): decode vectors, skid back-pressure,
// flush and mid-stream reset, each checked against hand-computed values.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_rv_decode_stage;
  logic clk;
  logic rst;
  logic flush;
  int   n_chk;
  int   n_pass;

  rv_decode_if #(.XLEN(32), .ALU_OP_W(4)) bus ();

  rv_decode_stage #(.XLEN(32), .ALU_OP_W(4)) dut (
    .clk_i  (clk),
    .rst_i  (rst),
    .flush_i(flush),
    .bus    (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Present one word with the consumer ready; it is accepted at the next edge.
  task automatic send1(input logic [31:0] inst, input logic [31:0] pc);
    bus.inst_valid_i = 1'b1;
    bus.inst_i       = inst;
    bus.pc_i         = pc;
    bus.dec_ready_i  = 1'b1;
    step();
    bus.inst_valid_i = 1'b0;
  endtask

  initial begin
    n_chk = 0;
    n_pass = 0;
    rst = 1'b1;
    flush = 1'b0;
    bus.inst_valid_i = 1'b0;
    bus.inst_i = '0;
    bus.pc_i = '0;
    bus.dec_ready_i = 1'b0;
    step();
    step();
    chk("rst_dec_valid", bus.dec_valid_o, 0);
    chk("rst_inst_ready", bus.inst_ready_o, 0);
    chk("rst_pc", bus.pc_o, 0);
    chk("rst_imm", bus.imm_o, 0);
    chk("rst_wr_reg", bus.wr_reg_o, 0);
    rst = 1'b0;
    step();
    chk("post_rst_ready", bus.inst_ready_o, 1);
    chk("post_rst_valid", bus.dec_valid_o, 0);

    // addi x5,x1,-1
    send1(32'hFFF08293, 32'h100);
    chk("addi_valid", bus.dec_valid_o, 1);
    chk("addi_alu", bus.alu_op_o, 0);
    chk("addi_imm", bus.imm_o, 64'hFFFFFFFF);
    chk("addi_rd", bus.rd_o, 5);
    chk("addi_rs1", bus.rs1_o, 1);
    chk("addi_wr_reg", bus.wr_reg_o, 1);
    chk("addi_src_b", bus.src_b_sel_o, 1);
    chk("addi_pc", bus.pc_o, 64'h100);
    chk("addi_illegal", bus.illegal_o, 0);

    // beq x0,x0,-4
    send1(32'hFE000EE3, 32'h104);
    chk("beq_imm", bus.imm_o, 64'hFFFFFFFC);
    chk("beq_pc_src", bus.pc_src_sel_o, 1);
    chk("beq_cmp", bus.cmp_sel_o, 0);
    chk("beq_src_a", bus.src_a_sel_o, 1);
    chk("beq_wr_reg", bus.wr_reg_o, 0);
    chk("beq_illegal", bus.illegal_o, 0);
    chk("beq_pc", bus.pc_o, 64'h104);

    // all-zero word
    send1(32'h00000000, 32'h108);
    chk("zero_valid", bus.dec_valid_o, 1);
    chk("zero_illegal", bus.illegal_o, 1);
    chk("zero_wr_reg", bus.wr_reg_o, 0);
    chk("zero_wr_mem", bus.wr_mem_o, 0);

    // load with funct3=3 (ld x1,0(x2) on RV32)
    send1(32'h00013083, 32'h10C);
    chk("ld_valid", bus.dec_valid_o, 1);
    chk("ld_illegal", bus.illegal_o, 1);
    chk("ld_wr_reg", bus.wr_reg_o, 0);
    chk("ld_wr_mem", bus.wr_mem_o, 0);

    // sw x2,8(x1)
    send1(32'h0020A423, 32'h110);
    chk("sw_imm", bus.imm_o, 8);
    chk("sw_wr_mem", bus.wr_mem_o, 1);
    chk("sw_wr_reg", bus.wr_reg_o, 0);
    chk("sw_size", bus.mem_size_o, 2);
    chk("sw_rs2", bus.rs2_o, 2);

    // lui x1,0x80000
    send1(32'h800000B7, 32'h114);
    chk("lui_imm", bus.imm_o, 64'h80000000);
    chk("lui_src_a", bus.src_a_sel_o, 3);
    chk("lui_src_b", bus.src_b_sel_o, 1);
    chk("lui_wr_reg", bus.wr_reg_o, 1);

    // sub x3,x1,x2 then sll with funct7=0x20 (illegal)
    send1(32'h402081B3, 32'h118);
    chk("sub_alu", bus.alu_op_o, 1);
    chk("sub_imm", bus.imm_o, 0);
    chk("sub_src_b", bus.src_b_sel_o, 0);
    send1(32'h402091B3, 32'h11C);
    chk("sll20_illegal", bus.illegal_o, 1);

    // addi x0,x0,0: write to x0 suppressed
    send1(32'h00000013, 32'h120);
    chk("nop_wr_reg", bus.wr_reg_o, 0);
    chk("nop_illegal", bus.illegal_o, 0);

    // mul x3,x1,x2
    send1(32'h022081B3, 32'h124);
`ifdef RV_DECODE_M_EXT_EN
    chk("mul_alu", bus.alu_op_o, 8);
    chk("mul_illegal", bus.illegal_o, 0);
    chk("mul_wr_reg", bus.wr_reg_o, 1);
`else
    chk("mul_illegal", bus.illegal_o, 1);
    chk("mul_wr_reg", bus.wr_reg_o, 0);
`endif
    step();
    chk("drain_valid", bus.dec_valid_o, 0);

    // Back-pressure: four words, consumer stalled, then released.
    bus.dec_ready_i = 1'b0;
    bus.inst_valid_i = 1'b1;
    bus.inst_i = 32'hFFF08293;
    bus.pc_i = 32'h200;
    step();
    chk("bp_a_ready", bus.inst_ready_o, 1);
    chk("bp_a_pc", bus.pc_o, 64'h200);
    bus.pc_i = 32'h204;
    step();
    chk("bp_skid_full_ready", bus.inst_ready_o, 0);
    chk("bp_hold_pc", bus.pc_o, 64'h200);
    bus.pc_i = 32'h208;
    step();
    chk("bp_stall_ready", bus.inst_ready_o, 0);
    chk("bp_stall_pc", bus.pc_o, 64'h200);
    chk("bp_stall_valid", bus.dec_valid_o, 1);
    bus.dec_ready_i = 1'b1;
    step();
    chk("bp_out_b", bus.pc_o, 64'h204);
    chk("bp_ready_back", bus.inst_ready_o, 1);
    step();
    chk("bp_out_c", bus.pc_o, 64'h208);
    bus.pc_i = 32'h20C;
    step();
    chk("bp_out_d", bus.pc_o, 64'h20C);
    bus.inst_valid_i = 1'b0;
    step();
    chk("bp_empty", bus.dec_valid_o, 0);

    // Flush with main+skid full and a word offered.
    bus.dec_ready_i = 1'b0;
    bus.inst_valid_i = 1'b1;
    bus.pc_i = 32'h300;
    step();
    bus.pc_i = 32'h304;
    step();
    chk("fl_full_valid", bus.dec_valid_o, 1);
    chk("fl_full_ready", bus.inst_ready_o, 0);
    bus.pc_i = 32'h308;
    flush = 1'b1;
    step();
    chk("fl_valid", bus.dec_valid_o, 0);
    chk("fl_ready", bus.inst_ready_o, 1);
    // Flush also beats an accept that lands on the same edge.
    bus.pc_i = 32'h30C;
    step();
    chk("fl_accept_dropped", bus.dec_valid_o, 0);
    flush = 1'b0;
    bus.inst_valid_i = 1'b0;
    bus.dec_ready_i = 1'b1;
    step();
    chk("fl_nothing_after", bus.dec_valid_o, 0);

    // Reset mid-stream.
    bus.dec_ready_i = 1'b0;
    bus.inst_valid_i = 1'b1;
    bus.inst_i = 32'hFFF08293;
    bus.pc_i = 32'h400;
    step();
    chk("mid_pre_valid", bus.dec_valid_o, 1);
    rst = 1'b1;
    step();
    chk("mid_rst_valid", bus.dec_valid_o, 0);
    chk("mid_rst_ready", bus.inst_ready_o, 0);
    chk("mid_rst_pc", bus.pc_o, 0);
    chk("mid_rst_imm", bus.imm_o, 0);
    chk("mid_rst_rd", bus.rd_o, 0);
    chk("mid_rst_wr_reg", bus.wr_reg_o, 0);
    rst = 1'b0;
    bus.inst_valid_i = 1'b0;
    step();
    chk("mid_release_ready", bus.inst_ready_o, 1);
    chk("mid_release_valid", bus.dec_valid_o, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
